// File: rtl/uart_rx.sv
// UART receiver (8N1) with a small receive FIFO and a word-addressed register
// interface: DATA (pop), STATUS (sticky W1C flags), CTRL (irq enable).
module uart_rx #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [3:0]  write_enable_i,
  input  logic [31:0] data_address_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        UART_RX,
  output logic        irq_o
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  logic [1:0]      settle_q, settle_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            irq_en_q, irq_en_d;
  logic [31:0]     data_q, data_d;
  logic            irq_q, irq_d;

  logic            fall;
  logic            push_req;
  logic            frame_set;
  logic            push_ok;
  logic            pop;
  logic            rd;
  logic            wr;
  logic [1:0]      addr;
  logic            not_empty;
  logic            full;
  logic            unused_bits;

  assign unused_bits = ^{data_address_i[31:4], data_address_i[1:0], data_i[31:4], data_i[1]};

  // The edge detector's history is held at 0 until the synchronizer has been
  // refilled from the real line, so a line already low at reset release is
  // not mistaken for a falling edge.
  always_comb begin
    sync1_d  = UART_RX;
    sync2_d  = sync1_q;
    settle_d = {settle_q[0], 1'b1};
    prev_d   = settle_q[1] ? sync2_q : 1'b0;
    fall     = prev_q & ~sync2_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = HALF_CNT;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (sync2_q) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = FULL_CNT;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_CNT;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          push_req  = sync2_q;
          frame_set = ~sync2_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO is only
  // an overrun when no DATA read accompanies it.
  always_comb begin
    wr        = enable_i & (|write_enable_i);
    rd        = enable_i & ~(|write_enable_i);
    addr      = data_address_i[3:2];
    not_empty = (count_q != '0);
    full      = (count_q == DEPTH_C);
    pop       = rd & (addr == 2'd0) & not_empty;
    push_ok   = push_req & (~full | pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    irq_en_d    = irq_en_q;
    if (wr && addr == 2'd1) begin
      if (data_i[2]) overrun_d = 1'b0;
      if (data_i[3]) frame_err_d = 1'b0;
    end
    if (wr && addr == 2'd2) begin
      irq_en_d = data_i[0];
    end
    if (push_req && full && !pop) overrun_d = 1'b1;
    if (frame_set) frame_err_d = 1'b1;

    data_d = data_q;
    if (rd) begin
      case (addr)
        2'd0:    data_d = not_empty ? {24'd0, mem_q[rd_ptr_q]} : 32'd0;
        2'd1:    data_d = {28'd0, frame_err_q, overrun_q, full, not_empty};
        2'd2:    data_d = {31'd0, irq_en_q};
        default: data_d = 32'd0;
      endcase
    end

    irq_d = irq_en_q & not_empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b0;
      settle_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      data_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      settle_q    <= settle_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_en_q    <= irq_en_d;
      data_q      <= data_d;
      irq_q       <= irq_d;
    end
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit, 4-entry FIFO:
// serial frames are driven on UART_RX and results read back over the bus.
module tb_uart_rx;

  logic        clk;
  logic        reset;
  logic        enable_i;
  logic [3:0]  write_enable_i;
  logic [31:0] data_address_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        UART_RX;
  logic        irq_o;

  int errors;
  int checks;
  logic [31:0] rdata;

  uart_rx #(.CLK_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable_i),
    .write_enable_i (write_enable_i),
    .data_address_i (data_address_i),
    .data_i         (data_i),
    .data_o         (data_o),
    .UART_RX        (UART_RX),
    .irq_o          (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, LSB first, 16 clocks per bit, line returned high afterwards.
  task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
    @(negedge clk);
    UART_RX = 1'b0;
    idleCycles(16);
    for (int i = 0; i < 8; i++) begin
      UART_RX = value[i];
      idleCycles(16);
    end
    UART_RX = stopBit;
    idleCycles(16);
    UART_RX = 1'b1;
    idleCycles(4);
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] value);
    @(negedge clk);
    enable_i       = 1'b1;
    write_enable_i = 4'h0;
    data_address_i = 32'h8000_0000 | {28'd0, addr, 2'b00};
    @(negedge clk);
    enable_i = 1'b0;
    value    = data_o;
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] value);
    @(negedge clk);
    enable_i       = 1'b1;
    write_enable_i = 4'hF;
    data_address_i = {28'd0, addr, 2'b00};
    data_i         = value;
    @(negedge clk);
    enable_i       = 1'b0;
    write_enable_i = 4'h0;
    data_i         = 32'd0;
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b1;
    enable_i       = 1'b0;
    write_enable_i = 4'h0;
    data_address_i = 32'd0;
    data_i         = 32'd0;
    UART_RX        = 1'b1;
    idleCycles(3);
    reset = 1'b0;
    idleCycles(2);

    checkOutput("reset data_o", data_o, 32'd0);
    checkOutput("reset irq_o", {31'd0, irq_o}, 32'd0);
    busRead(2'd1, rdata);
    checkOutput("reset STATUS", rdata, 32'd0);
    busRead(2'd2, rdata);
    checkOutput("reset CTRL", rdata, 32'd0);

    // Normal receive
    applyStimulus(8'hA5, 1'b1);
    busRead(2'd1, rdata);
    checkOutput("s1 STATUS", rdata, 32'h1);
    busRead(2'd0, rdata);
    checkOutput("s1 DATA", rdata, 32'h0000_00A5);
    busRead(2'd1, rdata);
    checkOutput("s1 STATUS after", rdata, 32'h0);

    // Overrun: fifth byte is dropped
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b1);
    busRead(2'd1, rdata);
    checkOutput("s2 STATUS", rdata, 32'h7);
    for (int b = 1; b <= 4; b++) begin
      busRead(2'd0, rdata);
      checkOutput("s2 DATA", rdata, 32'(b));
    end
    busRead(2'd0, rdata);
    checkOutput("s2 DATA empty", rdata, 32'd0);
    busRead(2'd1, rdata);
    checkOutput("s2 STATUS sticky", rdata, 32'h4);
    busWrite(2'd1, 32'h4);
    busRead(2'd1, rdata);
    checkOutput("s2 STATUS cleared", rdata, 32'h0);
    busRead(2'd3, rdata);
    checkOutput("s2 reg3 read", rdata, 32'h0);

    // Framing error
    applyStimulus(8'h81, 1'b0);
    busRead(2'd1, rdata);
    checkOutput("s3 STATUS", rdata, 32'h8);
    busWrite(2'd1, 32'h8);
    busRead(2'd1, rdata);
    checkOutput("s3 STATUS cleared", rdata, 32'h0);

    // Glitch, then a normal frame proves the FSM is back in IDLE
    @(negedge clk);
    UART_RX = 1'b0;
    idleCycles(4);
    UART_RX = 1'b1;
    idleCycles(40);
    busRead(2'd1, rdata);
    checkOutput("s4 STATUS", rdata, 32'h0);
    applyStimulus(8'h5A, 1'b1);
    busRead(2'd0, rdata);
    checkOutput("s4 DATA", rdata, 32'h0000_005A);
    busRead(2'd1, rdata);
    checkOutput("s4 STATUS after", rdata, 32'h0);

    // Interrupt
    busWrite(2'd2, 32'h1);
    busRead(2'd2, rdata);
    checkOutput("s5 CTRL", rdata, 32'h1);
    checkOutput("s5 irq idle", {31'd0, irq_o}, 32'd0);
    applyStimulus(8'h3C, 1'b1);
    checkOutput("s5 irq raised", {31'd0, irq_o}, 32'd1);
    busRead(2'd0, rdata);
    checkOutput("s5 DATA", rdata, 32'h0000_003C);
    idleCycles(1);
    checkOutput("s5 irq fallen", {31'd0, irq_o}, 32'd0);

    // Reset during data bit 3, line still low at release
    @(negedge clk);
    UART_RX = 1'b0;
    idleCycles(70);
    reset = 1'b1;
    idleCycles(3);
    reset = 1'b0;
    checkOutput("s6 data_o reset", data_o, 32'd0);
    checkOutput("s6 irq reset", {31'd0, irq_o}, 32'd0);
    idleCycles(20);
    UART_RX = 1'b1;
    idleCycles(20);
    busRead(2'd1, rdata);
    checkOutput("s6 STATUS idle", rdata, 32'h0);
    busRead(2'd2, rdata);
    checkOutput("s6 CTRL reset", rdata, 32'h0);
    applyStimulus(8'h55, 1'b1);
    busRead(2'd1, rdata);
    checkOutput("s6 STATUS", rdata, 32'h1);
    busRead(2'd0, rdata);
    checkOutput("s6 DATA", rdata, 32'h0000_0055);
    busRead(2'd1, rdata);
    checkOutput("s6 STATUS after", rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
